// File: rtl/seq_arith_unit.sv
// Sequential add/sub/multiply unit with valid/ready handshakes and an iterative shift-add multiplier.
// Optional hex seven-segment decode of result[3:0] is enabled by defining SEG7_DECODE_EN.
module seq_arith_unit #(
   parameter int WIDTH = 8
) (
   input  logic                 clk_2,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ovf,
   output logic                 busy,
   output logic [7:0]           seg
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_MUL,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_nextState;

   logic [1:0]           r_op;
   logic [WIDTH-1:0]     r_opA;
   logic [WIDTH-1:0]     r_opB;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic                 r_negate;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_ovf;

   logic                 w_accept;
   logic                 w_mulLast;
   logic [WIDTH-1:0]     w_magA;
   logic [WIDTH-1:0]     w_magB;
   logic [WIDTH:0]       w_extA;
   logic [WIDTH:0]       w_extB;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_accNext;
   logic [2*WIDTH-1:0]   w_prod;

   // Signed multiplies run on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
   assign w_magA    = (op[0] & a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign w_magB    = (op[0] & b[WIDTH-1]) ? (~b + 1'b1) : b;

   assign w_extA    = {r_opA[WIDTH-1], r_opA};
   assign w_extB    = {r_opB[WIDTH-1], r_opB};
   assign w_sum     = r_op[0] ? (w_extA - w_extB) : (w_extA + w_extB);

   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign w_mulLast = (r_cnt == CW'(WIDTH - 1));
   assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_prod    = r_negate ? (~w_accNext + 1'b1) : w_accNext;

   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_nextState = op[1] ? S_MUL : S_CALC;
            end
         end
         S_CALC: begin
            w_nextState = S_DONE;
         end
         S_MUL: begin
            if (w_mulLast) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Datapath: operands are captured only on acceptance, so input changes while busy are ignored.
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_opA    <= '0;
         r_opB    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_negate <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op     <= op;
                  r_opA    <= a;
                  r_opB    <= b;
                  r_acc    <= '0;
                  r_mcand  <= {{WIDTH{1'b0}}, w_magA};
                  r_mplier <= w_magB;
                  r_negate <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_cnt    <= '0;
               end
            end
            S_CALC: begin
               r_result <= {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
               r_ovf    <= w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            S_MUL: begin
               r_acc    <= w_accNext;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_mulLast) begin
                  r_result <= w_prod;
                  r_ovf    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result = r_result;
   assign ovf    = r_ovf;

`ifdef SEG7_DECODE_EN
   logic [7:0] r_seg;
   logic [1:0] r_resOp;
   logic [6:0] w_hex;

   always_comb begin
      w_hex = 7'h00;
      case (r_result[3:0])
         4'h0: w_hex = 7'h3F;
         4'h1: w_hex = 7'h06;
         4'h2: w_hex = 7'h5B;
         4'h3: w_hex = 7'h4F;
         4'h4: w_hex = 7'h66;
         4'h5: w_hex = 7'h6D;
         4'h6: w_hex = 7'h7D;
         4'h7: w_hex = 7'h07;
         4'h8: w_hex = 7'h7F;
         4'h9: w_hex = 7'h6F;
         4'hA: w_hex = 7'h77;
         4'hB: w_hex = 7'h7C;
         4'hC: w_hex = 7'h39;
         4'hD: w_hex = 7'h5E;
         4'hE: w_hex = 7'h79;
         4'hF: w_hex = 7'h71;
         default: w_hex = 7'h00;
      endcase
   end

   // r_resOp tracks the op that produced result, so a newly accepted op cannot change dp early.
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= 8'b0011_1111;
         r_resOp <= 2'b00;
      end else begin
         if ((r_state == S_CALC) || ((r_state == S_MUL) && w_mulLast)) begin
            r_resOp <= r_op;
         end
         r_seg <= {(r_resOp != 2'b10) & r_result[2*WIDTH-1], w_hex};
      end
   end

   assign seg = r_seg;
`else
   assign seg = 8'h00;
`endif

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed self-checking bench for seq_arith_unit (WIDTH=8) with an arithmetic reference model.
// Build with SEG7_DECODE_EN defined to also check the seven-segment decode.
module tb_seq_arith_unit;

   localparam int W = 8;

   logic          clk_2 = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready;
   logic          out_valid;
   logic          ovf;
   logic          busy;
   logic [2*W-1:0] result;
   logic [7:0]    seg;

   int total = 0;
   int bad = 0;

   logic [15:0] expR = '0;
   logic        expO = 1'b0;
   logic [1:0]  expOp = 2'b00;
   logic [15:0] heldR = '0;
   logic [1:0]  heldOp = 2'b00;
   logic        prevOv = 1'b0;
   bit          checkEn = 1'b0;

   seq_arith_unit #(.WIDTH(W)) dut (
      .clk_2     (clk_2),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .busy      (busy),
      .seg       (seg)
   );

   always #5 clk_2 = ~clk_2;

`ifdef SEG7_DECODE_EN
   logic [7:0] hexTab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   localparam logic [7:0] SEG_RESET = 8'b0011_1111;
`else
   localparam logic [7:0] SEG_RESET = 8'h00;
`endif

   // Display the low hex digit; dp shows the sign for every op except unsigned multiply.
   function automatic logic [7:0] segModel(input logic [15:0] r, input logic [1:0] o);
`ifdef SEG7_DECODE_EN
      logic [7:0] pat;
      pat = hexTab[r[3:0]];
      pat[7] = (o != 2'b10) && r[15];
      return pat;
`else
      return 8'h00;
`endif
   endfunction

   // Reference arithmetic on plain integers.
   task automatic computeModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [15:0] r, output logic ov);
      int sx, sy, ux, uy, v;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ux = int'({24'b0, x});
      uy = int'({24'b0, y});
      ov = 1'b0;
      case (o)
         2'b00: begin v = sx + sy; ov = (v > 127) || (v < -128); end
         2'b01: begin v = sx - sy; ov = (v > 127) || (v < -128); end
         2'b10: v = ux * uy;
         default: v = sx * sy;
      endcase
      r = 16'(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Continuous compare against the model on every cycle where outputs are defined.
   always @(negedge clk_2) begin
      if (rst_n && checkEn) begin
         checkOutput("busyVsReady", {31'b0, busy}, {31'b0, ~in_ready});
         if (out_valid) begin
            checkOutput("doneResult", {16'b0, result}, {16'b0, expR});
            checkOutput("doneOvf", {31'b0, ovf}, {31'b0, expO});
            checkOutput("doneInReady", {31'b0, in_ready}, 32'd0);
            if (prevOv) begin
               checkOutput("doneSeg", {24'b0, seg}, {24'b0, segModel(expR, expOp)});
            end
         end else if (in_ready) begin
            checkOutput("idleResult", {16'b0, result}, {16'b0, heldR});
            checkOutput("idleSeg", {24'b0, seg}, {24'b0, segModel(heldR, heldOp)});
         end
         prevOv = out_valid;
      end
   end

   task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [15:0] litR, input logic litO, input int litLat,
                                input int holdCycles);
      int n;
      computeModel(o, x, y, expR, expO);
      expOp = o;
      @(negedge clk_2);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk_2);
      n = 1;
      @(negedge clk_2);
      in_valid = 1'b0;
      op = 2'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      while (!out_valid && n < 40) begin
         @(negedge clk_2);
         n++;
      end
      if (!out_valid) begin
         total++;
         bad++;
         $display("[TB] FAIL timeout op=%0d actual=no_out_valid required=out_valid", o);
      end else begin
         checkOutput("latency", n, litLat);
         checkOutput("litResult", {16'b0, result}, {16'b0, litR});
         checkOutput("litOvf", {31'b0, ovf}, {31'b0, litO});
         for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk_2);
            in_valid = ~in_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            op = 2'($urandom);
            checkOutput("holdValid", {31'b0, out_valid}, 32'd1);
            checkOutput("holdResult", {16'b0, result}, {16'b0, litR});
         end
         @(negedge clk_2);
         in_valid = 1'b0;
         checkOutput("litSeg", {24'b0, seg}, {24'b0, segModel(litR, o)});
         out_ready = 1'b1;
         heldR = expR;
         heldOp = o;
         @(negedge clk_2);
         out_ready = 1'b0;
         checkOutput("postValid", {31'b0, out_valid}, 32'd0);
         checkOutput("postReady", {31'b0, in_ready}, 32'd1);
         checkOutput("postResult", {16'b0, result}, {16'b0, litR});
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "Result"}, {16'b0, result}, 32'd0);
      checkOutput({tag, "Ovf"}, {31'b0, ovf}, 32'd0);
      checkOutput({tag, "Valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, "Busy"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, "Ready"}, {31'b0, in_ready}, 32'd1);
      checkOutput({tag, "Seg"}, {24'b0, seg}, {24'b0, SEG_RESET});
   endtask

   initial begin
      #1;
      checkResetState("reset");
      @(negedge clk_2);
      #2 rst_n = 1'b1;
      checkEn = 1'b1;

      applyStimulus(2'b00, 8'd100, 8'd50, 16'h0096, 1'b1, 2, 0);
      applyStimulus(2'b01, 8'h80, 8'h01, 16'hFF7F, 1'b1, 2, 0);
      applyStimulus(2'b01, 8'd5, 8'd7, 16'hFFFE, 1'b0, 2, 0);
      applyStimulus(2'b00, 8'h7F, 8'h01, 16'h0080, 1'b1, 2, 0);
      applyStimulus(2'b00, 8'hFF, 8'hFF, 16'hFFFE, 1'b0, 2, 0);
      applyStimulus(2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 9, 0);
      applyStimulus(2'b10, 8'h0F, 8'h10, 16'h00F0, 1'b0, 9, 0);
      applyStimulus(2'b11, 8'h80, 8'h80, 16'h4000, 1'b0, 9, 0);
      applyStimulus(2'b11, 8'hFD, 8'd5, 16'hFFF1, 1'b0, 9, 0);
      applyStimulus(2'b11, 8'd0, 8'hF9, 16'h0000, 1'b0, 9, 0);
      applyStimulus(2'b11, 8'h7F, 8'h80, 16'hC080, 1'b0, 9, 0);
      applyStimulus(2'b10, 8'd12, 8'd13, 16'h009C, 1'b0, 9, 5);

      // Abort a signed multiply on its fourth MUL cycle.
      computeModel(2'b11, 8'hFD, 8'd5, expR, expO);
      expOp = 2'b11;
      @(negedge clk_2);
      in_valid = 1'b1;
      op = 2'b11;
      a = 8'hFD;
      b = 8'd5;
      @(posedge clk_2);
      @(negedge clk_2);
      in_valid = 1'b0;
      repeat (3) @(posedge clk_2);
      #2 rst_n = 1'b0;
      heldR = '0;
      heldOp = 2'b00;
      #1;
      checkResetState("abort");
      @(negedge clk_2);
      #2 rst_n = 1'b1;

      applyStimulus(2'b00, 8'd1, 8'd2, 16'h0003, 1'b0, 2, 0);
`ifdef SEG7_DECODE_EN
      checkOutput("afterAbortSeg", {24'b0, seg}, 32'h4F);
`endif

      repeat (2) @(negedge clk_2);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
